// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;
    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;
endpackage

// File: rtl/register_file_param_read_port.sv
// One asynchronous read port: range check, hardwired zero, write bypass, array read.
module rf_read_port #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              run_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [WIDTH-1:0]  mem_data_i,
    output logic [WIDTH-1:0]  rd_data_o
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic in_range;
    assign in_range = ({1'b0, addr_i} < DEPTH_W);

    always_comb begin
        rd_data_o = '0;
        if (!run_i || !in_range) begin
            rd_data_o = '0;
        end else if (ZERO_REG && (addr_i == '0)) begin
            rd_data_o = '0;
        end else if (BYPASS && wr_en_i && (wr_addr_i == addr_i)) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = mem_data_i;
        end
    end
endmodule

// File: rtl/register_file_param.sv
// Parametrised 2R1W register file; a clear sweep zeroes the reset-less array after reset.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RegA,
    input  logic [ADDR_W-1:0] RegB,
    input  logic [ADDR_W-1:0] RegC,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic              RegWrite,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              ready
);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              run;
    logic              wr_ok;
    logic              wr_en_run;
    logic [ADDR_W-1:0] ra_idx, rb_idx;

    assign run       = (state_q == RF_RUN);
    assign wr_en_run = run && RegWrite;
    assign wr_ok     = wr_en_run && ({1'b0, RegC} < DEPTH_W) &&
                       !(ZERO_REG && (RegC == '0));
    assign ready     = ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            RF_CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_RUN;
            end
        endcase
    end

    // Array has no reset; the sweep owns the write port until it finishes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == RF_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_ok) begin
                mem[RegC] <= dataIn;
            end
        end
    end

    // Out-of-range addresses are masked by the read port; keep the index legal.
    assign ra_idx = ({1'b0, RegA} < DEPTH_W) ? RegA : '0;
    assign rb_idx = ({1'b0, RegB} < DEPTH_W) ? RegB : '0;

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd1 (
        .run_i(run), .addr_i(RegA), .wr_en_i(wr_en_run), .wr_addr_i(RegC),
        .wr_data_i(dataIn), .mem_data_i(mem[ra_idx]), .rd_data_o(RD1)
    );

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd2 (
        .run_i(run), .addr_i(RegB), .wr_en_i(wr_en_run), .wr_addr_i(RegC),
        .wr_data_i(dataIn), .mem_data_i(mem[rb_idx]), .rd_data_o(RD2)
    );
endmodule

// File: tb/tb_register_file_param.sv
// Bench: two configurations (32/zero/bypass and 20/no-zero/no-bypass) share stimulus.
module tb_register_file_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  RegA = '0, RegB = '0, RegC = '0;
    logic [31:0] dataIn = '0;
    logic        RegWrite = 1'b0;
    logic [31:0] RD1_a, RD2_a, RD1_b, RD2_b;
    logic        ready_a, ready_b;

    int tests = 0;
    int fails = 0;

    // Reference model: contents, ready flag and remaining sweep edges per instance.
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [20];
    bit          rdy_a = 0, rdy_b = 0;
    int          left_a = 32, left_b = 20;

    always #5 clk = ~clk;

    register_file_param dut_a (
        .clk(clk), .reset(reset), .RegA(RegA), .RegB(RegB), .RegC(RegC),
        .dataIn(dataIn), .RegWrite(RegWrite), .RD1(RD1_a), .RD2(RD2_a), .ready(ready_a)
    );

    register_file_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .RegA(RegA), .RegB(RegB), .RegC(RegC),
        .dataIn(dataIn), .RegWrite(RegWrite), .RD1(RD1_b), .RD2(RD2_b), .ready(ready_b)
    );

    function automatic logic [31:0] exp_rd(input bit inst_b, input logic [4:0] a);
        int  d   = inst_b ? 20 : 32;
        bit  rdy = inst_b ? rdy_b : rdy_a;
        if (!rdy || int'(a) >= d) return 32'h0;
        if (!inst_b && a == 5'd0) return 32'h0;
        if (!inst_b && RegWrite && RegC == a) return dataIn;
        return inst_b ? mem_b[a] : mem_a[a];
    endfunction

    task automatic model_edge();
        if (reset) begin
            rdy_a = 0; left_a = 32;
            rdy_b = 0; left_b = 20;
            return;
        end
        if (!rdy_a) begin
            left_a--;
            if (left_a == 0) begin
                rdy_a = 1;
                foreach (mem_a[i]) mem_a[i] = 32'h0;
            end
        end else if (RegWrite && RegC != 5'd0) begin
            mem_a[RegC] = dataIn;
        end
        if (!rdy_b) begin
            left_b--;
            if (left_b == 0) begin
                rdy_b = 1;
                foreach (mem_b[i]) mem_b[i] = 32'h0;
            end
        end else if (RegWrite && int'(RegC) < 20) begin
            mem_b[RegC] = dataIn;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int na = 0, nb = 0;
        reset = 1; RegA = 5'd2; RegB = 5'd2;
        tick(); tick();
        tests++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0 || RD1_a !== 32'h0 || RD1_b !== 32'h0) begin
            fails++;
            $display("FAIL reset_state ready=%b/%b rd1=%h/%h want 0", ready_a, ready_b, RD1_a, RD1_b);
        end
        // Hold a write to reg 2 through the sweep: must be ignored while clearing.
        reset = 0; RegWrite = 1; RegC = 5'd2; dataIn = 32'h55;
        #1;
        for (int n = 1; n <= 40 && !ready_a; n++) begin
            tick();
            if (ready_b && nb == 0) nb = n;
            if (ready_a) na = n;
            tests++;
            if (RD1_a !== exp_rd(0, RegA) || RD2_b !== exp_rd(1, RegB)) begin
                fails++;
                $display("FAIL sweep_read n=%0d a=%h b=%h want %h/%h", n, RD1_a, RD2_b,
                         exp_rd(0, RegA), exp_rd(1, RegB));
            end
        end
        tests++;
        if (na !== 32) begin
            fails++;
            $display("FAIL ready_latency_a got %0d want 32", na);
        end
        tests++;
        if (nb !== 20) begin
            fails++;
            $display("FAIL ready_latency_b got %0d want 20", nb);
        end
        RegWrite = 0;
        for (int a = 0; a < 32; a++) begin
            RegA = 5'(a); RegB = 5'(31 - a);
            #1;
            tests++;
            if (RD1_a !== 32'h0 || RD2_a !== 32'h0 || RD1_b !== exp_rd(1, RegA)) begin
                fails++;
                $display("FAIL cleared_read addr=%0d got %h/%h/%h want 0/0/%h", a, RD1_a, RD2_a,
                         RD1_b, exp_rd(1, RegA));
            end
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1; RegC = 5'd5; dataIn = 32'hDEADBEEF; RegA = 5'd1; RegB = 5'd1;
        tick();
        RegWrite = 0; RegA = 5'd5; RegB = 5'd5;
        #1;
        tests++;
        if (RD1_a !== 32'hDEADBEEF || RD2_a !== 32'hDEADBEEF || RD1_b !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read got %h/%h/%h want deadbeef", RD1_a, RD2_a, RD1_b);
        end
        RegWrite = 1; RegC = 5'd5; dataIn = 32'h1234;
        #1;
        tests++;
        if (RD1_a !== 32'h1234 || RD2_a !== 32'h1234 || RD1_b !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL bypass got %h/%h/%h want 1234/1234/deadbeef", RD1_a, RD2_a, RD1_b);
        end
        tick();
        RegWrite = 0;
        #1;
        tests++;
        if (RD1_b !== 32'h1234) begin
            fails++;
            $display("FAIL post_write_b got %h want 1234", RD1_b);
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1; RegC = 5'd0; dataIn = 32'hFFFFFFFF; RegA = 5'd0; RegB = 5'd0;
        #1;
        tests++;
        if (RD1_a !== 32'h0 || RD1_b !== 32'h0) begin
            fails++;
            $display("FAIL zero_same_cycle got %h/%h want 0/0", RD1_a, RD1_b);
        end
        tick();
        RegWrite = 0;
        #1;
        tests++;
        if (RD1_a !== 32'h0 || RD2_b !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL zero_after got %h/%h want 0/ffffffff", RD1_a, RD2_b);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] old5;
        old5 = mem_b[5];
        RegWrite = 1; RegC = 5'd25; dataIn = 32'hAA;
        tick();
        RegWrite = 0; RegA = 5'd25; RegB = 5'd5;
        #1;
        tests++;
        if (RD1_b !== 32'h0 || RD2_b !== old5 || RD1_a !== 32'hAA) begin
            fails++;
            $display("FAIL out_of_range got %h/%h/%h want 0/%h/aa", RD1_b, RD2_b, RD1_a, old5);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            RegWrite = 1'($urandom);
            RegC = 5'($urandom);
            RegA = ($urandom_range(0, 3) == 0) ? RegC : 5'($urandom);
            RegB = ($urandom_range(0, 3) == 0) ? RegC : 5'($urandom);
            dataIn = $urandom;
            #1;
            tests++;
            if (RD1_a !== exp_rd(0, RegA) || RD2_a !== exp_rd(0, RegB) ||
                RD1_b !== exp_rd(1, RegA) || RD2_b !== exp_rd(1, RegB) ||
                ready_a !== 1'b1 || ready_b !== 1'b1) begin
                fails++;
                $display("FAIL random i=%0d A=%0d B=%0d got %h %h %h %h want %h %h %h %h",
                         i, RegA, RegB, RD1_a, RD2_a, RD1_b, RD2_b, exp_rd(0, RegA),
                         exp_rd(0, RegB), exp_rd(1, RegA), exp_rd(1, RegB));
            end
            tick();
        end
        RegWrite = 0;
    endtask

    task automatic test_reset_restart();
        int n;
        reset = 1; tick(); reset = 0;
        repeat (10) tick();
        reset = 1; tick(); reset = 0;
        n = 0;
        while (!ready_a && n < 40) begin tick(); n++; end
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL restart_mid_sweep got %0d want 32", n);
        end
        RegWrite = 1; RegC = 5'd3; dataIn = 32'h33; tick();
        RegC = 5'd7; dataIn = 32'h77; tick();
        RegWrite = 0; RegA = 5'd3; RegB = 5'd7;
        #1;
        tests++;
        if (RD1_a !== 32'h33 || RD2_b !== 32'h77) begin
            fails++;
            $display("FAIL run_write got %h/%h want 33/77", RD1_a, RD2_b);
        end
        reset = 1; tick(); reset = 0;
        n = 0;
        while (!ready_a && n < 40) begin
            tick(); n++;
            tests++;
            if (n < 32 && (ready_a !== 1'b0 || RD1_a !== 32'h0)) begin
                fails++;
                $display("FAIL restart_low n=%0d ready=%b rd=%h want 0/0", n, ready_a, RD1_a);
            end
        end
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL restart_run got %0d want 32", n);
        end
        tests++;
        if (RD1_a !== 32'h0 || RD2_a !== 32'h0 || RD1_b !== 32'h0 || RD2_b !== 32'h0) begin
            fails++;
            $display("FAIL cleared_3_7 got %h %h %h %h want 0", RD1_a, RD2_a, RD1_b, RD2_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_out_of_range();
        test_random();
        test_reset_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the MIPS datapath register file. It has two asynchronous read ports and one synchronous write port, with configurable width and depth. Storage is a RAM-style array with no per-entry reset, so a post-reset clear sequencer sweeps zeros into every entry. Optional hardwired register 0 and optional write-to-read bypass support the pipelined datapath.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), register address width (derived, do not override)
ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are dropped
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
RegA  input  ADDR_W  read address, port 1
RegB  input  ADDR_W  read address, port 2
RegC  input  ADDR_W  write address
dataIn  input  WIDTH  write data
RegWrite  input  1  write enable
RD1  output  WIDTH  read data, port 1 (combinational)
RD2  output  WIDTH  read data, port 2 (combinational)
ready  output  1  high once the clear sweep is done; writes are accepted only when high

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- State machine has two states, RF_CLEAR and RF_RUN.
- While reset is high at an edge: state<=RF_CLEAR, clr_cnt<=0, ready<=0. The array is not touched at a reset edge.
- RF_CLEAR:
  - Each edge writes 0 to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt==DEPTH-1, that entry is written, then state<=RF_RUN and ready<=1.
  - ready therefore rises DEPTH edges after the first edge with reset low.
- RF_RUN: stays in RF_RUN until reset.
- During RF_CLEAR:
  - RegWrite is ignored (no write, no bypass).
  - RD1 and RD2 are forced to 0.
- Reset mid-sweep or mid-run: the sweep restarts from entry 0. Partially cleared or old contents are overwritten by the new sweep.
- Write (RF_RUN only): if RegWrite=1, RegC<DEPTH, and not (ZERO_REG and RegC==0), then mem[RegC]<=dataIn at the edge.
- Read (RF_RUN), evaluated for RD1 from RegA; RD2 is identical using RegB:
  1. If RegA>=DEPTH, RD1=0.
  2. Else if ZERO_REG and RegA==0, RD1=0.
  3. Else if BYPASS, RegWrite=1, and RegC==RegA, RD1=dataIn (same cycle, before the edge).
  4. Else RD1=mem[RegA].
- With BYPASS=0, written data becomes visible on the first cycle after the write edge.
- Both ports may read the same address; both may bypass at once.
- Out-of-range write: dropped silently, with no aliasing onto a wrapped address.
- Width rules: no truncation or extension. dataIn, mem, and RD* are all WIDTH bits. clr_cnt is ADDR_W bits and never exceeds DEPTH-1.
- Reset values: ready=0 and RD1=RD2=0 from the reset edge until the sweep completes.

Decomposition:
- Shared package regfile_pkg holds:
  - rf_state_t enum {RF_CLEAR, RF_RUN}
  - default constants RF_WIDTH=32 and RF_DEPTH=32
- One natural sub-module, rf_read_port. It is instantiated twice and implements the read-priority chain (range check, zero register, bypass, array read) for one port.
- The clear FSM and array stay in the top module.

Test Plan:
1. Reset for 2 cycles, then release with DEPTH=32 -> ready rises exactly 32 edges after release. RD1/RD2=0 throughout. After ready, every address reads 0.
2. In RF_RUN: write 0xDEADBEEF to reg 5, and on the next cycle set RegA=5, RegB=5 -> RD1=RD2=0xDEADBEEF. Also, with RegWrite=1, RegC=5, dataIn=0x1234 and RegA=5 in the same cycle -> RD1=0x1234 before the edge (BYPASS=1). With BYPASS=0, RD1=0xDEADBEEF.
3. Write 0xFFFFFFFF to reg 0 with ZERO_REG=1 and RegA=0 -> RD1=0 both in the same cycle and afterwards. With ZERO_REG=0, RD1=0xFFFFFFFF on the next cycle.
4. DEPTH=20: write 0xAA to RegC=25, then read RegA=25 and RegA=5 -> both read 0; mem[5] is unchanged.
5. Assert reset at sweep count 10, then again after writing regs 3 and 7 in RF_RUN -> the sweep restarts from 0. ready is low for exactly DEPTH edges after release. Regs 3 and 7 read 0 afterwards.
6. Hold RegWrite=1 with RegC=2, dataIn=0x55 during the whole RF_CLEAR -> no bypass and no write. mem[2] reads 0 once ready=1.
